// File: rtl/led_chaser_if.sv
// Control and display bundle between a pattern source/consumer and led_chaser.
// The master side drives mode/speed/pause; the chaser (slave) drives the LEDs and step strobe.
interface led_chaser_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic             pause;
  logic [WIDTH-1:0] leds_n;
  logic             step;

  modport master (output mode, speed, pause, input leds_n, step);
  modport slave  (input mode, speed, pause, output leds_n, step);
endinterface

// File: rtl/led_chaser.sv
// Parametrised active-low LED pattern sequencer: bounce, rotate-left/right and bar-fill,
// with pause, run-time speed, an optional dimmed trail and a one-cycle step strobe.
module led_chaser #(
  parameter int WIDTH      = 8,
  parameter int BASE_DIV   = 4,
  parameter int PRESCALE_W = 24,
  parameter int TRAIL      = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  led_chaser_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROL    = 2'd1,
    MODE_ROR    = 2'd2,
    MODE_BAR    = 2'd3
  } mode_e;

  logic [PRESCALE_W-1:0] cnt, cnt_nx, limit;
  logic [WIDTH-1:0]      pattern, pattern_nx;
  logic [WIDTH-1:0]      prev, prev_nx;
  logic [WIDTH-1:0]      lit;
  logic                  dir, dir_nx;
  logic                  tick;
  logic [1:0]            pwm;
  mode_e                 act_mode, act_mode_nx, mode_in;

  assign mode_in = mode_e'(bus.mode);

  // >= rather than == so that lowering speed mid-count ticks next cycle instead of wrapping
  always_comb begin
    limit  = (PRESCALE_W'(BASE_DIV) << bus.speed) - PRESCALE_W'(1);
    cnt_nx = cnt;
    tick   = 1'b0;
    if (!bus.pause) begin
      if (cnt >= limit) begin
        tick   = 1'b1;
        cnt_nx = '0;
      end else begin
        cnt_nx = cnt + PRESCALE_W'(1);
      end
    end
  end

  always_comb begin
    pattern_nx  = pattern;
    prev_nx     = prev;
    dir_nx      = dir;
    act_mode_nx = act_mode;
    if (tick) begin
      if (mode_in != act_mode) begin
        // a mode change only reloads; the first shift happens on the following tick
        act_mode_nx = mode_in;
        pattern_nx  = WIDTH'(1);
        dir_nx      = 1'b1;
        prev_nx     = '0;
      end else begin
        prev_nx = pattern;
        case (act_mode)
          MODE_BOUNCE: begin
            if (dir && pattern[WIDTH-1]) begin
              pattern_nx = pattern >> 1;
              dir_nx     = 1'b0;
            end else if (!dir && pattern[0]) begin
              pattern_nx = pattern << 1;
              dir_nx     = 1'b1;
            end else if (dir) begin
              pattern_nx = pattern << 1;
            end else begin
              pattern_nx = pattern >> 1;
            end
          end
          MODE_ROL: pattern_nx = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
          MODE_ROR: pattern_nx = {pattern[0], pattern[WIDTH-1:1]};
          MODE_BAR: pattern_nx = (&pattern) ? WIDTH'(1) : {pattern[WIDTH-2:0], 1'b1};
          default:  pattern_nx = pattern;
        endcase
      end
    end
  end

  // Trail LED is lit only when pwm==0, giving 1/4 duty; bar-fill never shows it
  always_comb begin
    lit = pattern;
    if (TRAIL != 0 && act_mode != MODE_BAR && pwm == 2'd0)
      lit = pattern | (prev & ~pattern);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt        <= '0;
      pattern    <= WIDTH'(1);
      prev       <= '0;
      dir        <= 1'b1;
      act_mode   <= MODE_BOUNCE;
      pwm        <= '0;
      bus.step   <= 1'b0;
      bus.leds_n <= ~WIDTH'(1);
    end else begin
      cnt        <= cnt_nx;
      pattern    <= pattern_nx;
      prev       <= prev_nx;
      dir        <= dir_nx;
      act_mode   <= act_mode_nx;
      pwm        <= pwm + 2'd1;
      bus.step   <= tick;
      bus.leds_n <= ~lit;
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser (WIDTH=8, BASE_DIV=4, TRAIL=1): per-cycle scoreboard
// from a reference model plus targeted pattern, timing, pause, trail and reset checks.
module tb_led_chaser;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  led_chaser_if #(.WIDTH(8)) bus ();

  led_chaser #(
    .WIDTH(8), .BASE_DIV(4), .PRESCALE_W(24), .TRAIL(1)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int unsigned m_cnt;
  int          m_pwm;
  logic [7:0]  m_pat, m_prev, m_leds;
  logic [1:0]  m_act;
  logic        m_dir, m_step;
  logic [8:0]  sb_q [$];

  task automatic model_step();
    logic [7:0]  lt;
    int unsigned lim;
    bit          tk;
    if (!rst_n) begin
      m_cnt = 0; m_pat = 8'h01; m_prev = 8'h00; m_dir = 1'b1; m_act = 2'd0;
      m_pwm = 0; m_step = 1'b0; m_leds = 8'hFE;
    end else begin
      lt = m_pat;
      if (m_act != 2'd3 && m_pwm == 0) lt = lt | (m_prev & ~m_pat);
      m_leds = ~lt;
      m_pwm  = (m_pwm + 1) % 4;
      lim    = (4 << bus.speed) - 1;
      tk     = 1'b0;
      if (!bus.pause) begin
        if (m_cnt >= lim) begin tk = 1'b1; m_cnt = 0; end
        else m_cnt++;
      end
      m_step = tk;
      if (tk) begin
        if (bus.mode != m_act) begin
          m_act = bus.mode; m_pat = 8'h01; m_dir = 1'b1; m_prev = 8'h00;
        end else begin
          m_prev = m_pat;
          case (m_act)
            2'd0: begin
              if (m_dir && m_pat == 8'h80) begin m_pat = 8'h40; m_dir = 1'b0; end
              else if (!m_dir && m_pat == 8'h01) begin m_pat = 8'h02; m_dir = 1'b1; end
              else m_pat = m_dir ? (m_pat << 1) : (m_pat >> 1);
            end
            2'd1:    m_pat = (m_pat == 8'h80) ? 8'h01 : (m_pat << 1);
            2'd2:    m_pat = (m_pat == 8'h01) ? 8'h80 : (m_pat >> 1);
            default: m_pat = (m_pat == 8'hFF) ? 8'h01 : {m_pat[6:0], 1'b1};
          endcase
        end
      end
    end
  endtask

  // advance one clock: model pushes the expected outputs, then return at the sampling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    sb_q.push_back({m_leds, m_step});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] e;
    int first = -1;
    rst_n = 1'b0; bus.mode = 2'd0; bus.speed = 2'd0; bus.pause = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_reset got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      n_cmp++;
      if (bus.leds_n !== 8'hFE || bus.step !== 1'b0) begin n_err++; $display("FAIL reset_hold got=%h/%b exp=fe/0", bus.leds_n, bus.step); end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 12 && first < 0; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_reset got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (bus.step) first = c;
    end
    n_cmp++;
    if (first !== 4) begin n_err++; $display("FAIL first_step got=%0d exp=4", first); end
    cycle();
    e = sb_q.pop_front(); n_cmp++;
    if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_reset got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
    // pattern 2 plus trail of LED0, since pwm is 0 on this edge
    n_cmp++;
    if (bus.leds_n !== 8'hFC) begin n_err++; $display("FAIL first_leds got=%h exp=fc", bus.leds_n); end
  endtask

  task automatic test_bounce();
    logic [8:0] e;
    logic [7:0] s1, got, ex;
    logic [7:0] exp_q [$];
    int stage = 0, last = -1, steps = 0, t1 = -1, t2 = -1;
    rst_n = 1'b0; bus.mode = 2'd0; bus.speed = 2'd0;
    cycle();
    e = sb_q.pop_front(); n_cmp++;
    if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_bounce got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
    rst_n = 1'b1;
    exp_q = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    for (int c = 0; c < 200 && (exp_q.size() > 0 || stage != 0); c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_bounce got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (stage == 2) begin
        stage = 0; got = ~(s1 | bus.leds_n); ex = exp_q.pop_front(); n_cmp++;
        if (got !== ex) begin n_err++; $display("FAIL bounce_pat got=%h exp=%h", got, ex); end
      end else if (stage == 1) begin
        s1 = bus.leds_n; stage = 2;
      end
      if (bus.step && exp_q.size() > 0) begin
        if (last >= 0) begin
          n_cmp++;
          if (c - last != 4) begin n_err++; $display("FAIL bounce_period got=%0d exp=4", c - last); end
        end
        last = c; stage = 1;
      end
    end
    if (exp_q.size() != 0) begin n_cmp++; n_err++; $display("FAIL bounce_timeout left=%0d exp=0", exp_q.size()); end
    bus.speed = 2'd2;
    for (int c = 0; c < 100 && steps < 3; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_bounce got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (bus.step) begin
        steps++;
        if (steps == 2) t1 = c;
        if (steps == 3) t2 = c;
      end
    end
    n_cmp++;
    if (t2 - t1 != 16) begin n_err++; $display("FAIL bounce_speed2_period got=%0d exp=16", t2 - t1); end
  endtask

  task automatic test_rotate();
    logic [8:0] e;
    logic [7:0] s1, got, ex;
    logic [7:0] exp_q [$];
    int stage;
    bus.speed = 2'd0;
    for (int ph = 0; ph < 2; ph++) begin
      stage = 0;
      if (ph == 0) begin
        bus.mode = 2'd1;
        exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      end else begin
        bus.mode = 2'd2;
        exp_q = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
      end
      for (int c = 0; c < 200 && (exp_q.size() > 0 || stage != 0); c++) begin
        cycle();
        e = sb_q.pop_front(); n_cmp++;
        if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_rotate got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
        if (stage == 2) begin
          stage = 0; got = ~(s1 | bus.leds_n); ex = exp_q.pop_front(); n_cmp++;
          if (got !== ex) begin n_err++; $display("FAIL rotate%0d_pat got=%h exp=%h", ph, got, ex); end
        end else if (stage == 1) begin
          s1 = bus.leds_n; stage = 2;
        end
        if (bus.step && exp_q.size() > 0) stage = 1;
      end
      if (exp_q.size() != 0) begin n_cmp++; n_err++; $display("FAIL rotate_timeout left=%0d exp=0", exp_q.size()); end
    end
  endtask

  task automatic test_bar();
    logic [8:0] e;
    logic [7:0] s1, ex;
    logic [7:0] exp_q [$];
    int stage = 0;
    bus.mode = 2'd3;
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
    for (int c = 0; c < 200 && (exp_q.size() > 0 || stage != 0); c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_bar got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (stage == 2) begin
        stage = 0; ex = exp_q.pop_front(); n_cmp++;
        // no trail in bar-fill: every sample shows the pattern alone
        if (~s1 !== ex || ~bus.leds_n !== ex) begin n_err++; $display("FAIL bar_pat got=%h,%h exp=%h", ~s1, ~bus.leds_n, ex); end
      end else if (stage == 1) begin
        s1 = bus.leds_n; stage = 2;
      end
      if (bus.step && exp_q.size() > 0) stage = 1;
    end
    if (exp_q.size() != 0) begin n_cmp++; n_err++; $display("FAIL bar_timeout left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_pause_speed();
    logic [8:0] e;
    logic [7:0] held;
    int seen = 0, lat = -1, bad = 0;
    bus.mode = 2'd3; bus.speed = 2'd0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_pause got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (bus.step) seen = 1;
    end
    if (!seen) begin n_cmp++; n_err++; $display("FAIL pause_sync_timeout got=0 exp=1"); end
    cycle();
    e = sb_q.pop_front(); n_cmp++;
    if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_pause got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
    held = bus.leds_n; bus.pause = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_pause got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      n_cmp++;
      if (bus.step !== 1'b0 || bus.leds_n !== held) begin n_err++; $display("FAIL pause_hold got=%h/%b exp=%h/0", bus.leds_n, bus.step, held); end
    end
    n_cmp++;
    if (dut.cnt !== 24'd1) begin n_err++; $display("FAIL pause_cnt got=%0d exp=1", dut.cnt); end
    bus.pause = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_pause got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (bus.step) lat = c;
    end
    n_cmp++;
    if (lat !== 3) begin n_err++; $display("FAIL pause_resume got=%0d exp=3", lat); end
    bus.speed = 2'd3; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_speed got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (bus.step) seen = 1;
    end
    if (!seen) begin n_cmp++; n_err++; $display("FAIL speed3_timeout got=0 exp=1"); end
    for (int c = 0; c < 20; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_speed got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (bus.step) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL speed3_early_step got=%0d exp=0", bad); end
    bus.speed = 2'd0;
    cycle();
    e = sb_q.pop_front(); n_cmp++;
    if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_speed got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
    n_cmp++;
    if (bus.step !== 1'b1) begin n_err++; $display("FAIL speed_drop_tick got=%b exp=1", bus.step); end
  endtask

  task automatic test_trail_reset();
    logic [8:0] e;
    int steps = 0, z3 = 0, z2 = 0, first = -1;
    bus.mode = 2'd0; bus.speed = 2'd0; bus.pause = 1'b0; rst_n = 1'b0;
    cycle();
    e = sb_q.pop_front(); n_cmp++;
    if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_trail got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
    rst_n = 1'b1;
    for (int c = 0; c < 40 && steps < 3; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_trail got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (bus.step) steps++;
    end
    if (steps != 3) begin n_cmp++; n_err++; $display("FAIL trail_timeout got=%0d exp=3", steps); end
    // pattern is now 8 with prev 4
    for (int c = 0; c < 4; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_trail got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (!bus.leds_n[3]) z3++;
      if (!bus.leds_n[2]) z2++;
    end
    n_cmp++;
    if (z3 != 4) begin n_err++; $display("FAIL trail_main got=%0d exp=4", z3); end
    n_cmp++;
    if (z2 != 1) begin n_err++; $display("FAIL trail_duty got=%0d exp=1", z2); end
    cycle();
    e = sb_q.pop_front(); n_cmp++;
    if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_trail got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
    rst_n = 1'b0;
    cycle();
    e = sb_q.pop_front(); n_cmp++;
    if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_trail got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
    n_cmp++;
    if (bus.leds_n !== 8'hFE || bus.step !== 1'b0 || dut.cnt !== 24'd0) begin
      n_err++; $display("FAIL midrun_reset got=%h/%b/cnt%0d exp=fe/0/cnt0", bus.leds_n, bus.step, dut.cnt);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 12 && first < 0; c++) begin
      cycle();
      e = sb_q.pop_front(); n_cmp++;
      if ({bus.leds_n, bus.step} !== e) begin n_err++; $display("FAIL sb_trail got=%h/%b exp=%h/%b", bus.leds_n, bus.step, e[8:1], e[0]); end
      if (bus.step) first = c;
    end
    n_cmp++;
    if (first !== 4) begin n_err++; $display("FAIL midrun_first_step got=%0d exp=4", first); end
  endtask

  initial begin
    rst_n = 1'b0; bus.mode = 2'd0; bus.speed = 2'd0; bus.pause = 1'b0;
    test_reset();
    test_bounce();
    test_rotate();
    test_bar();
    test_pause_speed();
    test_trail_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
# led_chaser

Parametrised LED pattern sequencer driving a bank of active-low LEDs on the PMOD header of the iCESugar nano. It generalises the single-width bounce chaser: LED count, base step rate and run-time speed are configurable, and it adds four pattern modes, pause, an optional dimmed trail via PWM and a step strobe for downstream blocks. It sits directly between the board clock and the PMOD pins; all outputs are registered.

## Interface
- WIDTH, 8, number of LEDs; legal range 2..32
- BASE_DIV, 4, step period in clocks at speed=0; legal range ≥2
- PRESCALE_W, 24, prescaler counter width; BASE_DIV<<3 must fit in PRESCALE_W bits
- TRAIL, 1, 1 = previous position shown dimmed (1/4 duty); 0 = off
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- mode  in  2  0 bounce, 1 rotate-left, 2 rotate-right, 3 bar-fill
- speed  in  2  step period = BASE_DIV<<speed clocks
- pause  in  1  high freezes prescaler and pattern
- leds_n  out  WIDTH  LED drive, active-low, bit i = LED i
- step  out  1  one-cycle strobe, high in the cycle the pattern register holds a new value

## Operation
- Internal state: prescaler cnt[PRESCALE_W-1:0], pattern[WIDTH-1:0], prev[WIDTH-1:0], dir (1=up/left), act_mode[1:0], pwm[1:0].
- Reset (RST_N low at an edge): cnt=0, pattern=1, prev=0, dir=1, act_mode=0, pwm=0, step=0, leds_n=~1 (only LED0 lit). Reset mid-operation has identical effect; no partial state survives.
- Prescaler: limit=(BASE_DIV<<speed)-1. If pause: cnt holds, no tick. Else if cnt>=limit: tick, cnt<=0. Else cnt<=cnt+1. The ≥ compare makes a speed reduction mid-count tick on the next cycle, never wrap.
- On tick, if mode!=act_mode: act_mode<=mode, pattern<=1, dir<=1, prev<=0 (reload, no shift). Mode input is ignored between ticks.
- On tick with mode==act_mode, prev<=pattern and:
  - bounce: dir=1 and pattern[WIDTH-1] → pattern>>1, dir<=0; dir=0 and pattern[0] → pattern<<1, dir<=1; else shift in dir. Ends are visited once (…,64,128,64,…).
  - rotate-left: pattern<<1, bit WIDTH-1 wraps to bit 0.
  - rotate-right: pattern>>1, bit 0 wraps to bit WIDTH-1.
  - bar-fill: pattern all ones → pattern<=1; else pattern<=(pattern<<1)|1.
- pwm increments every cycle, free-running, wraps 3→0; pause does not stop it.
- Display: lit = pattern | (TRAIL && act_mode!=3 && pwm==0 ? prev & ~pattern : 0); leds_n<=~lit each cycle.
- Exactly one bit of pattern set in modes 0-2 at all times; never all-zero in any mode.

## Timing
- Tick decided at edge t (cnt>=limit seen); pattern, prev, dir, act_mode and step=1 all update at edge t; leds_n reflects them at edge t+1 (one cycle latency).
- step high exactly one cycle per tick, including mode-reload ticks; never high while pause.
- Unpaused, step period = BASE_DIV<<speed clocks exactly; first tick after reset at cycle BASE_DIV<<speed.
- pause asserted: change stops at the next edge; deasserted: cnt resumes from held value, no lost or extra tick.
- Simultaneous pause and cnt>=limit: pause wins, no tick.
- Trail duty: prev-only LED low on leds_n 1 of every 4 cycles, phase set by pwm from reset.

## Test plan
- Reset: hold RST_N low 3 cycles → leds_n=8'hFE, step=0; release, speed=0 → first step at cycle 4, leds_n=~8'h02 one cycle later.
- Bounce, WIDTH=8, TRAIL=0: run 16 ticks → pattern 1,2,4,…,128,64,…,1,2; step period 4 clocks; speed=2 → period 16.
- Rotate modes: mode=1 from reload → 1,2,…,128,1; mode=2 → 1,128,64,…,1; mode change between ticks takes effect only at the next tick, pattern=1.
- Bar-fill: mode=3 → 1,3,7,…,255,1; no trail even with TRAIL=1.
- Pause/speed: pause mid-period for 10 cycles → pattern and cnt frozen, step resumes after the remaining count; change speed 3→0 with cnt=20 → tick next cycle.
- Trail + reset mid-run: TRAIL=1, bounce at pattern=8 → LED3 low 4/4 cycles, LED2 low 1/4 cycles; assert RST_N low mid-period → leds_n=8'hFE next edge+1, cnt=0.
